// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL layout and byte-lane merge helper for the
// memory-mapped multi-channel timer.
package mmio_timer_pkg;

  localparam logic [31:0] OFF_CNT_LO = 32'h0000_0000;
  localparam logic [31:0] OFF_CNT_HI = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;
  localparam logic [31:0] OFF_CMP_LO = 32'h0000_000C;
  localparam logic [31:0] OFF_CMP_HI = 32'h0000_0010;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0014;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_AR        = 1;
  localparam int CTRL_IE        = 2;
  localparam int CTRL_PRESC_LSB = 8;

  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_timer_channel.sv
// One timer channel: 64-bit counter, prescaler, compare/match flag with
// optional auto-reload, local register writes and read mux.
module timer_channel
  import mmio_timer_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_sel,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_off,
  input  logic [31:0] wr_data,
  input  logic        rd_sel,
  input  logic [31:0] rd_off,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [63:0]        cnt_r, cnt_next_s;
  logic [63:0]        cmp_r, cmp_next_s;
  ctrl_t              ctrl_r, ctrl_next_s;
  logic [PRESC_W-1:0] presc_r, presc_next_s;
  logic [PRESC_W-1:0] pc_r, pc_next_s;
  logic               match_r, match_next_s;
  logic               irq_r, irq_next_s;
  logic               tick_s, cmp_hit_s;
  logic               wr_cnt_lo_s, wr_cnt_hi_s, wr_ctrl_s;
  logic               wr_cmp_lo_s, wr_cmp_hi_s, wr_status_s;
  logic [31:0]        rd_mux_s;

  // Local write decode within the channel block
  always_comb begin
    wr_cnt_lo_s = wr_sel && (wr_off == OFF_CNT_LO);
    wr_cnt_hi_s = wr_sel && (wr_off == OFF_CNT_HI);
    wr_ctrl_s   = wr_sel && (wr_off == OFF_CTRL);
    wr_cmp_lo_s = wr_sel && (wr_off == OFF_CMP_LO);
    wr_cmp_hi_s = wr_sel && (wr_off == OFF_CMP_HI);
    wr_status_s = wr_sel && (wr_off == OFF_STATUS);
  end

  // Next-state for prescaler, counter, compare, control and match flag
  always_comb begin
    tick_s    = ctrl_r.en && (pc_r == presc_r);
    cmp_hit_s = tick_s && (cnt_r == cmp_r);

    cnt_next_s = cnt_r;
    if (tick_s) begin
      if (cmp_hit_s && ctrl_r.ar) begin
        cnt_next_s = 64'd0;
      end else begin
        cnt_next_s = cnt_r + 64'd1;
      end
    end else if (!ctrl_r.en) begin
      // Software may only load the counter while it is stopped
      if (wr_cnt_lo_s) begin
        cnt_next_s[31:0] = byte_merge(cnt_r[31:0], wr_data, wr_be);
      end else begin
        cnt_next_s[31:0] = cnt_r[31:0];
      end
      if (wr_cnt_hi_s) begin
        cnt_next_s[63:32] = byte_merge(cnt_r[63:32], wr_data, wr_be);
      end else begin
        cnt_next_s[63:32] = cnt_r[63:32];
      end
    end else begin
      cnt_next_s = cnt_r;
    end

    if (wr_ctrl_s) begin
      pc_next_s = '0;
    end else if (!ctrl_r.en) begin
      pc_next_s = '0;
    end else if (tick_s) begin
      pc_next_s = '0;
    end else begin
      pc_next_s = pc_r + PRESC_W'(1);
    end

    if (cmp_hit_s) begin
      match_next_s = 1'b1;
    end else if (wr_status_s && wr_be[0] && wr_data[0]) begin
      match_next_s = 1'b0;
    end else begin
      match_next_s = match_r;
    end

    cmp_next_s = cmp_r;
    if (wr_cmp_lo_s) begin
      cmp_next_s[31:0] = byte_merge(cmp_r[31:0], wr_data, wr_be);
    end else begin
      cmp_next_s[31:0] = cmp_r[31:0];
    end
    if (wr_cmp_hi_s) begin
      cmp_next_s[63:32] = byte_merge(cmp_r[63:32], wr_data, wr_be);
    end else begin
      cmp_next_s[63:32] = cmp_r[63:32];
    end

    ctrl_next_s  = ctrl_r;
    presc_next_s = presc_r;
    if (wr_ctrl_s) begin
      if (wr_be[0]) begin
        ctrl_next_s.en = wr_data[CTRL_EN];
        ctrl_next_s.ar = wr_data[CTRL_AR];
        ctrl_next_s.ie = wr_data[CTRL_IE];
      end else begin
        ctrl_next_s = ctrl_r;
      end
      for (int i = 0; i < PRESC_W; i++) begin
        if (wr_be[(CTRL_PRESC_LSB + i) / 8]) begin
          presc_next_s[i] = wr_data[CTRL_PRESC_LSB + i];
        end else begin
          presc_next_s[i] = presc_r[i];
        end
      end
    end else begin
      ctrl_next_s  = ctrl_r;
      presc_next_s = presc_r;
    end

    irq_next_s = match_next_s && ctrl_next_s.ie;
  end

  // Channel state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_r   <= 64'd0;
      cmp_r   <= 64'd0;
      ctrl_r  <= '0;
      presc_r <= '0;
      pc_r    <= '0;
      match_r <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      cnt_r   <= cnt_next_s;
      cmp_r   <= cmp_next_s;
      ctrl_r  <= ctrl_next_s;
      presc_r <= presc_next_s;
      pc_r    <= pc_next_s;
      match_r <= match_next_s;
      irq_r   <= irq_next_s;
    end
  end

  // Register read mux; reserved CTRL/STATUS bits read as zero
  always_comb begin
    case (rd_off)
      OFF_CNT_LO: rd_mux_s = cnt_r[31:0];
      OFF_CNT_HI: rd_mux_s = cnt_r[63:32];
      OFF_CTRL:   rd_mux_s = (32'(presc_r) << CTRL_PRESC_LSB) |
                             {29'd0, ctrl_r.ie, ctrl_r.ar, ctrl_r.en};
      OFF_CMP_LO: rd_mux_s = cmp_r[31:0];
      OFF_CMP_HI: rd_mux_s = cmp_r[63:32];
      OFF_STATUS: rd_mux_s = {31'd0, match_r};
      default:    rd_mux_s = 32'd0;
    endcase
    if (rd_sel) begin
      rd_data = rd_mux_s;
    end else begin
      rd_data = 32'd0;
    end
  end

  assign irq = irq_r;

endmodule

// File: rtl/mmio_timer.sv
// Multi-channel MMIO timer top: address decode, per-channel select and
// OR-reduced read data. Channel 0 keeps the legacy cycle-counter map.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] CH_STRIDE = 32'h0000_0020,
  parameter int          PRESC_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        dbus_en_i,
  input  logic [31:0]       dbus_write_addr_i,
  input  logic [31:0]       dbus_write_data_i,
  input  logic [31:0]       dbus_read_addr_i,
  output logic [31:0]       dbus_read_data_o,
  output logic              dbus_read_hit_o,
  output logic [NUM_CH-1:0] irq_o
);

  localparam int          STRIDE_SH   = $clog2(CH_STRIDE);
  localparam logic [31:0] BLOCK_BYTES = 32'(NUM_CH) * CH_STRIDE;

  logic [31:0]             wr_rel_s, rd_rel_s;
  logic [31:0]             wr_ch_s, rd_ch_s, wr_off_s, rd_off_s;
  logic                    wr_in_s, rd_in_s;
  logic [NUM_CH-1:0]       wr_sel_s, rd_sel_s, ch_irq_s;
  logic [NUM_CH-1:0][31:0] ch_rd_s;
  logic [31:0]             rd_or_s;

  // Map bus addresses onto a channel index and in-block offset
  always_comb begin
    wr_rel_s = dbus_write_addr_i - BASE_ADDR;
    rd_rel_s = dbus_read_addr_i - BASE_ADDR;
    wr_in_s  = (dbus_write_addr_i >= BASE_ADDR) && (wr_rel_s < BLOCK_BYTES);
    rd_in_s  = (dbus_read_addr_i >= BASE_ADDR) && (rd_rel_s < BLOCK_BYTES);
    wr_ch_s  = wr_rel_s >> STRIDE_SH;
    rd_ch_s  = rd_rel_s >> STRIDE_SH;
    wr_off_s = wr_rel_s & (CH_STRIDE - 32'd1);
    rd_off_s = rd_rel_s & (CH_STRIDE - 32'd1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_sel_s[c] = wr_in_s && (dbus_en_i != 4'b0000) && (wr_ch_s == 32'(c));
    assign rd_sel_s[c] = rd_in_s && (rd_ch_s == 32'(c));

    timer_channel #(
      .PRESC_W (PRESC_W)
    ) u_channel (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wr_sel  (wr_sel_s[c]),
      .wr_be   (dbus_en_i),
      .wr_off  (wr_off_s),
      .wr_data (dbus_write_data_i),
      .rd_sel  (rd_sel_s[c]),
      .rd_off  (rd_off_s),
      .rd_data (ch_rd_s[c]),
      .irq     (ch_irq_s[c])
    );
  end

  // Unselected channels drive zero, so an OR yields the selected word
  always_comb begin
    rd_or_s = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_or_s = rd_or_s | ch_rd_s[c];
    end
  end

  assign dbus_read_data_o = rd_or_s;
  assign dbus_read_hit_o  = rd_in_s;
  assign irq_o            = ch_irq_s;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed plus randomized bench for mmio_timer against a behavioural model.
module tb_mmio_timer;

  localparam int          NCH    = 4;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] STRIDE = 32'h0000_0020;
  localparam logic [31:0] SPAN   = 32'h0000_0080;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [3:0]     dbus_en_i = 4'h0;
  logic [31:0]    wa = 32'd0, wd = 32'd0, ra = 32'h8000_0000;
  logic [31:0]    dbus_read_data_o;
  logic           dbus_read_hit_o;
  logic [NCH-1:0] irq_o;

  always #50 clk_i = ~clk_i;

  mmio_timer #(
    .NUM_CH(NCH), .BASE_ADDR(BASE), .CH_STRIDE(STRIDE), .PRESC_W(8)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .dbus_en_i         (dbus_en_i),
    .dbus_write_addr_i (wa),
    .dbus_write_data_i (wd),
    .dbus_read_addr_i  (ra),
    .dbus_read_data_o  (dbus_read_data_o),
    .dbus_read_hit_o   (dbus_read_hit_o),
    .irq_o             (irq_o)
  );

  logic [63:0] m_cnt [NCH];
  logic [63:0] m_cmp [NCH];
  bit          m_en [NCH], m_ar [NCH], m_ie [NCH], m_match [NCH];
  int unsigned m_presc [NCH], m_pc [NCH];
  int          n_pass = 0, n_total = 0, n_fail = 0;

  function automatic logic [31:0] lane_mix(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~m) | (new_w & m);
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    int c;
    logic [31:0] off;
    if (!m_hit(a)) return 32'd0;
    c   = int'((a - BASE) / STRIDE);
    off = (a - BASE) % STRIDE;
    case (off)
      32'h00:  return m_cnt[c][31:0];
      32'h04:  return m_cnt[c][63:32];
      32'h08:  return {16'd0, 8'(m_presc[c]), 5'd0, m_ie[c], m_ar[c], m_en[c]};
      32'h0C:  return m_cmp[c][31:0];
      32'h10:  return m_cmp[c][63:32];
      32'h14:  return {31'd0, m_match[c]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_irq();
    logic [31:0] v;
    v = 32'd0;
    for (int c = 0; c < NCH; c++) v[c] = m_match[c] & m_ie[c];
    return v;
  endfunction

  // One clock edge of the reference model, from the inputs seen at that edge
  task automatic model_step();
    logic [31:0] rel, off, cw;
    bit wsel, tick, hit;
    if (!rst_ni) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 64'd0; m_cmp[c] = 64'd0; m_en[c] = 1'b0; m_ar[c] = 1'b0;
        m_ie[c] = 1'b0; m_match[c] = 1'b0; m_presc[c] = 0; m_pc[c] = 0;
      end
      return;
    end
    rel = wa - BASE;
    off = rel % STRIDE;
    for (int c = 0; c < NCH; c++) begin
      wsel = (dbus_en_i != 4'h0) && m_hit(wa) && ((rel / STRIDE) == 32'(c));
      tick = m_en[c] && (m_pc[c] == m_presc[c]);
      hit  = tick && (m_cnt[c] == m_cmp[c]);
      if (tick) m_cnt[c] = (hit && m_ar[c]) ? 64'd0 : m_cnt[c] + 64'd1;
      else if (!m_en[c] && wsel && off == 32'h00) m_cnt[c][31:0] = lane_mix(m_cnt[c][31:0], wd, dbus_en_i);
      else if (!m_en[c] && wsel && off == 32'h04) m_cnt[c][63:32] = lane_mix(m_cnt[c][63:32], wd, dbus_en_i);
      if (hit) m_match[c] = 1'b1;
      else if (wsel && off == 32'h14 && dbus_en_i[0] && wd[0]) m_match[c] = 1'b0;
      if ((wsel && off == 32'h08) || !m_en[c] || tick) m_pc[c] = 0;
      else m_pc[c] = m_pc[c] + 1;
      if (wsel && off == 32'h0C) m_cmp[c][31:0] = lane_mix(m_cmp[c][31:0], wd, dbus_en_i);
      if (wsel && off == 32'h10) m_cmp[c][63:32] = lane_mix(m_cmp[c][63:32], wd, dbus_en_i);
      if (wsel && off == 32'h08) begin
        cw = lane_mix({16'd0, 8'(m_presc[c]), 5'd0, m_ie[c], m_ar[c], m_en[c]}, wd, dbus_en_i);
        m_en[c] = cw[0]; m_ar[c] = cw[1]; m_ie[c] = cw[2];
        m_presc[c] = {24'd0, cw[15:8]};
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
    dbus_en_i = 4'h0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] be = 4'hF);
    wa = a; wd = d; dbus_en_i = be;
    step();
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(string tag, logic [31:0] a);
    ra = a;
    #1;
    check({tag, " data"}, dbus_read_data_o, m_read(a));
    check({tag, " hit"}, {31'd0, dbus_read_hit_o}, {31'd0, m_hit(a)});
  endtask

  task automatic chk_lit(string tag, logic [31:0] a, logic [31:0] exp);
    ra = a;
    #1;
    check(tag, dbus_read_data_o, exp);
  endtask

  task automatic chk_irq(string tag);
    check(tag, {28'd0, irq_o}, m_irq());
  endtask

  task automatic chk_all(string tag);
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < 6; o++)
        chk_rd(tag, BASE + 32'(c) * STRIDE + 32'(o * 4));
    chk_irq({tag, " irq"});
  endtask

  initial begin
    logic [31:0] ch1, ch2, ch3, a, d;
    logic [31:0] exp_seq [6];
    ch1 = BASE + STRIDE; ch2 = BASE + 2 * STRIDE; ch3 = BASE + 3 * STRIDE;
    exp_seq[0] = 32'd1; exp_seq[1] = 32'd2; exp_seq[2] = 32'd3;
    exp_seq[3] = 32'd4; exp_seq[4] = 32'd0; exp_seq[5] = 32'd1;

    // Reset state
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    chk_all("reset");
    chk_lit("reset cnt0", BASE, 32'd0);

    // Legacy channel 0 map
    wr(BASE, 32'h10);
    wr(BASE + 32'h4, 32'h1);
    wr(BASE + 32'h8, 32'h1);
    idle(5);
    chk_lit("legacy lo", BASE, 32'h15);
    chk_lit("legacy hi", BASE + 32'h4, 32'h1);
    chk_rd("legacy", BASE);

    // Prescaler on ch1
    wr(ch1 + 32'h8, 32'h0000_0301);
    idle(12);
    chk_lit("presc 12cyc", ch1, 32'd3);
    idle(2);
    wr(ch1 + 32'h8, 32'h0000_0301);
    idle(3);
    chk_lit("presc restart", ch1, 32'd3);
    idle(1);
    chk_lit("presc tick", ch1, 32'd4);
    chk_rd("presc ctrl", ch1 + 32'h8);

    // Compare with auto-reload on ch2
    wr(ch2 + 32'hC, 32'd4);
    wr(ch2 + 32'h8, 32'h7);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_lit("ar seq", ch2, exp_seq[k]);
      if (k == 3) check("irq2 before", {31'd0, irq_o[2]}, 32'd0);
      if (k >= 4) check("irq2 set", {31'd0, irq_o[2]}, 32'd1);
    end
    idle(3);
    chk_lit("ar at cmp", ch2, 32'd4);
    check("irq2 held", {31'd0, irq_o[2]}, 32'd1);
    wr(ch2 + 32'h14, 32'h1);
    chk_lit("w1c race", ch2 + 32'h14, 32'd1);
    wr(ch2 + 32'h14, 32'h1);
    chk_lit("w1c clear", ch2 + 32'h14, 32'd0);
    check("irq2 drop", {31'd0, irq_o[2]}, 32'd0);
    chk_irq("irq model");

    // Wrap, write protect and byte lanes on ch3
    wr(ch3, 32'hFFFF_FFFE);
    wr(ch3 + 32'h4, 32'hFFFF_FFFF);
    wr(ch3 + 32'h8, 32'h1);
    idle(1);
    chk_lit("wrap ff", ch3, 32'hFFFF_FFFF);
    idle(1);
    chk_lit("wrap lo", ch3, 32'd0);
    chk_lit("wrap hi", ch3 + 32'h4, 32'd0);
    chk_lit("wrap flag", ch3 + 32'h14, 32'd0);
    wr(ch3, 32'h1234);
    chk_lit("cnt protect", ch3, 32'd1);
    wr(ch3 + 32'hC, 32'hAABB_CCDD, 4'b0010);
    chk_lit("cmp byte", ch3 + 32'hC, 32'h0000_CC00);
    chk_all("pre reset");

    // Reset mid-count
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < 6; o++)
        chk_lit("mid reset", BASE + 32'(c) * STRIDE + 32'(o * 4), 32'd0);
    check("mid reset irq", {28'd0, irq_o}, 32'd0);
    chk_lit("unmapped", BASE + 32'h18, 32'd0);
    ra = BASE + 32'h18; #1;
    check("unmapped hit", {31'd0, dbus_read_hit_o}, 32'd1);
    ra = BASE + SPAN; #1;
    check("outside hit", {31'd0, dbus_read_hit_o}, 32'd0);
    ra = BASE - 32'd4; #1;
    check("below hit", {31'd0, dbus_read_hit_o}, 32'd0);
    check("below data", dbus_read_data_o, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
      end else if ($urandom_range(0, 1) == 1) begin
        int idx;
        idx = int'($urandom_range(0, 6));
        a = BASE + 32'($urandom_range(0, NCH - 1)) * STRIDE + 32'(idx * 4);
        if ($urandom_range(0, 19) == 0) a = $urandom;
        case (idx)
          0, 3:    d = 32'($urandom_range(0, 40));
          1, 4:    d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
          2:       d = ($urandom & 32'hFFFF_00F8) | 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 7));
          default: d = $urandom;
        endcase
        wr(a, d, 4'($urandom_range(0, 15)));
      end else begin
        step();
      end
      chk_irq("rand irq");
      a = BASE + 32'($urandom_range(0, NCH - 1)) * STRIDE + 32'($urandom_range(0, 7) * 4);
      chk_rd("rand rd", a);
      if (i % 100 == 99) chk_all("rand all");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
